// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encodings, memory command codes,
// the halt opcode and default datapath widths.
// S_HALT exists only when HALT_DETECT_EN is defined.
package cpu_pkg;

   localparam int DEF_ADDR_W = 9;
   localparam int DEF_DATA_W = 16;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   // Top three bits of an instruction word hold the opcode.
   localparam logic [2:0] OPC_HALT = 3'b111;

   typedef enum logic [2:0] {
      S_RESET = 3'd0,
      S_IF1   = 3'd1,
      S_IF2   = 3'd2,
      S_UPDPC = 3'd3,
      S_EXEC  = 3'd4
`ifdef HALT_DETECT_EN
      ,
      S_HALT  = 3'd5
`endif
   } fetch_state_t;

   // Memory command for a controller data access.
   function automatic logic [1:0] dmem_cmd(input logic write);
      return write ? MEM_WRITE : MEM_READ;
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register. A branch load has priority over the sequential
// increment. Arithmetic wraps modulo 2^ADDR_W without any flag.
module fetch_pc_reg #(
   parameter int              ADDR_W    = 9,
   parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc_en,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_nxt;

   assign pc_inc = pc + 1'b1;

   // Priority select: branch target, then pc+1, otherwise hold.
   always_comb begin
      pc_nxt = pc;
      if (load_en) begin
         pc_nxt = load_val;
      end else if (inc_en) begin
         pc_nxt = pc_inc;
      end
   end

   // PC state register with synchronous reset to the reset vector.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_VAL;
      end else begin
         pc <= pc_nxt;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC and the single memory port, reads each
// instruction from synchronous RAM into ir, hands it to the controller with a
// one-cycle exec_start pulse and lends the memory port to the controller while
// it executes.
// Optional halt detection is enabled by defining HALT_DETECT_EN.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_RESET | idle cycle after reset, memory port quiet
// S_IF1   | present pc with READ; RAM registers the word at this edge
// S_IF2   | keep READ on pc; mem_rdata valid, captured into ir at the edge
// S_UPDPC | pulse exec_start, advance pc (or divert to S_HALT on halt opcode)
// S_EXEC  | controller owns the memory port; waits for exec_done
// S_HALT  | fetch stopped, halted=1, left only by reset (HALT_DETECT_EN)
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_cmd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ir,
   output logic              ir_valid,
   output logic              exec_start,
   input  logic              exec_done,
   input  logic              dmem_req,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic              dmem_write,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   fetch_state_t state;
   fetch_state_t state_nxt;
   logic         pc_inc_en;
   logic         pc_load_en;

`ifdef HALT_DETECT_EN
   logic         halt_op;
   assign halt_op = (ir[DATA_W-1 -: 3] == OPC_HALT);
`endif

   fetch_pc_reg #(
      .ADDR_W    (ADDR_W),
      .RESET_VAL (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .reset    (reset),
      .load_en  (pc_load_en),
      .load_val (pc_in),
      .inc_en   (pc_inc_en),
      .pc       (pc)
   );

   // State register; reset abandons any in-flight fetch or data access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_RESET;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus memory port mux and PC controls, decoded from state.
   always_comb begin
      state_nxt  = state;
      mem_addr   = pc;
      mem_cmd    = MEM_NONE;
      exec_start = 1'b0;
      pc_inc_en  = 1'b0;
      pc_load_en = 1'b0;
      case (state)
         S_RESET: begin
            state_nxt = S_IF1;
         end
         S_IF1: begin
            mem_cmd   = MEM_READ;
            state_nxt = S_IF2;
         end
         S_IF2: begin
            mem_cmd   = MEM_READ;
            state_nxt = S_UPDPC;
         end
         S_UPDPC: begin
`ifdef HALT_DETECT_EN
            if (halt_op) begin
               state_nxt = S_HALT;
            end else begin
               exec_start = 1'b1;
               pc_inc_en  = 1'b1;
               state_nxt  = S_EXEC;
            end
`else
            exec_start = 1'b1;
            pc_inc_en  = 1'b1;
            state_nxt  = S_EXEC;
`endif
         end
         S_EXEC: begin
            if (dmem_req) begin
               mem_addr = dmem_addr;
               mem_cmd  = dmem_cmd(dmem_write);
            end
            // A branch in the same cycle as exec_done still lands, so the
            // following fetch starts from the branch target.
            pc_load_en = pc_load;
            if (exec_done) begin
               state_nxt = S_IF1;
            end
         end
`ifdef HALT_DETECT_EN
         S_HALT: begin
            state_nxt = S_HALT;
         end
`endif
         default: begin
            state_nxt = S_RESET;
         end
      endcase
   end

   // Instruction register: loaded once per fetch, held through execution.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir       <= '0;
         ir_valid <= 1'b0;
      end else if (state == S_IF2) begin
         ir       <= mem_rdata;
         ir_valid <= 1'b1;
      end
   end

`ifdef HALT_DETECT_EN
   // Halt flag follows entry into S_HALT and stays until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         halted <= 1'b0;
      end else begin
         halted <= (state_nxt == S_HALT);
      end
   end
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed sequences, a vector
// table for the execute-phase memory mux, and a randomized program run
// checked against an instruction-level model.
module tb_instruction_fetch;

   localparam int AW = 9;
   localparam int DW = 16;
   localparam logic [1:0] C_NONE  = 2'b00;
   localparam logic [1:0] C_READ  = 2'b01;
   localparam logic [1:0] C_WRITE = 2'b10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] mem_addr;
   logic [1:0]    mem_cmd;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] ir;
   logic          ir_valid;
   logic          exec_start;
   logic          exec_done = 1'b0;
   logic          dmem_req = 1'b0;
   logic [AW-1:0] dmem_addr = '0;
   logic          dmem_write = 1'b0;
   logic          pc_load = 1'b0;
   logic [AW-1:0] pc_in = '0;
   logic [AW-1:0] pc;
   logic          halted;

   instruction_fetch dut (
      .clk        (clk),
      .reset      (reset),
      .mem_addr   (mem_addr),
      .mem_cmd    (mem_cmd),
      .mem_rdata  (mem_rdata),
      .ir         (ir),
      .ir_valid   (ir_valid),
      .exec_start (exec_start),
      .exec_done  (exec_done),
      .dmem_req   (dmem_req),
      .dmem_addr  (dmem_addr),
      .dmem_write (dmem_write),
      .pc_load    (pc_load),
      .pc_in      (pc_in),
      .pc         (pc),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: data appears the cycle after a READ address.
   logic [DW-1:0] ram [0:511];
   always @(posedge clk) begin
      if (mem_cmd == C_READ) mem_rdata <= ram[mem_addr];
   end

   int n_start = 0;
   always @(negedge clk) begin
      if (exec_start === 1'b1) n_start++;
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      dmem_req   = 1'b0;
      dmem_write = 1'b0;
      dmem_addr  = '0;
      pc_load    = 1'b0;
      pc_in      = '0;
      exec_done  = 1'b0;
   endtask

   task automatic do_reset();
      clr();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   typedef struct {
      logic          req;
      logic          wr;
      logic [AW-1:0] a;
      logic [AW-1:0] exp_addr;
      logic [1:0]    exp_cmd;
   } vec_t;
   vec_t tv [5];

   int            n0;
   int            waited;
   int            len;
   logic [AW-1:0] exp_fetch;
   logic [AW-1:0] pc_m;
   logic [AW-1:0] e_addr;
   logic [1:0]    e_cmd;
   logic          abort;

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < 512; k++) ram[k] = 16'(k * 37 + 5) & 16'h7FFF;
      ram[0]      = 16'hD105;
      ram[1]      = 16'h1111;
      ram[2]      = 16'h2222;
      ram[3]      = 16'h3333;
      ram[9'h020] = 16'h4020;
      ram[9'h1FF] = 16'h51FF;

      // Power-on fetch
      n0 = n_start;
      do_reset();
      check("rst_cmd", 32'(mem_cmd), 32'(C_NONE));
      check("rst_pc", 32'(pc), 0);
      check("rst_ir", 32'(ir), 0);
      check("rst_ir_valid", 32'(ir_valid), 0);
      check("rst_start", 32'(exec_start), 0);
      check("rst_halted", 32'(halted), 0);
      step();
      check("po_if1_cmd", 32'(mem_cmd), 32'(C_READ));
      check("po_if1_addr", 32'(mem_addr), 0);
      step();
      check("po_if2_cmd", 32'(mem_cmd), 32'(C_READ));
      check("po_if2_addr", 32'(mem_addr), 0);
      step();
      check("po_start", 32'(exec_start), 1);
      check("po_ir", 32'(ir), 32'(16'hD105));
      check("po_ir_valid", 32'(ir_valid), 1);
      step();
      check("po_pc", 32'(pc), 1);
      check("po_start_low", 32'(exec_start), 0);

      // Sequential program, exec_done two cycles after each exec_start
      for (int i = 1; i <= 3; i++) begin
         step();
         exec_done = 1'b1;
         step();
         exec_done = 1'b0;
         #1;
         check("seq_if1_cmd", 32'(mem_cmd), 32'(C_READ));
         check("seq_if1_addr", 32'(mem_addr), 32'(i));
         step();
         check("seq_if2_addr", 32'(mem_addr), 32'(i));
         step();
         check("seq_start", 32'(exec_start), 1);
         check("seq_ir", 32'(ir), 32'(ram[i]));
         step();
         check("seq_pc", 32'(pc), 32'(i + 1));
      end
      check("seq_start_count", 32'(n_start - n0), 4);

      // Execute-phase memory mux, pc = 4
      tv[0] = '{1'b1, 1'b1, 9'h140, 9'h140, C_WRITE};
      tv[1] = '{1'b1, 1'b0, 9'h0AB, 9'h0AB, C_READ};
      tv[2] = '{1'b0, 1'b1, 9'h155, 9'h004, C_NONE};
      tv[3] = '{1'b1, 1'b1, 9'h1FF, 9'h1FF, C_WRITE};
      tv[4] = '{1'b0, 1'b0, 9'h000, 9'h004, C_NONE};
      for (int i = 0; i < 5; i++) begin
         dmem_req   = tv[i].req;
         dmem_write = tv[i].wr;
         dmem_addr  = tv[i].a;
         #1;
         check("dmem_addr", 32'(mem_addr), 32'(tv[i].exp_addr));
         check("dmem_cmd", 32'(mem_cmd), 32'(tv[i].exp_cmd));
         step();
      end
      clr();
      check("dmem_pc_hold", 32'(pc), 4);

      // Branch together with done; pc_load in S_IF1 is ignored
      pc_load = 1'b1;
      pc_in   = 9'h020;
      exec_done = 1'b1;
      step();
      clr();
      pc_load = 1'b1;
      pc_in   = 9'h0AA;
      #1;
      check("br_if1_addr", 32'(mem_addr), 32'(9'h020));
      step();
      clr();
      check("br_if2_addr", 32'(mem_addr), 32'(9'h020));
      step();
      check("br_ir", 32'(ir), 32'(16'h4020));
      step();
      check("br_pc", 32'(pc), 32'(9'h021));

      // Wrap at 0x1FF, then reset during S_IF2
      pc_load = 1'b1;
      pc_in   = 9'h1FF;
      exec_done = 1'b1;
      step();
      clr();
      check("wrap_if1_addr", 32'(mem_addr), 32'(9'h1FF));
      step();
      step();
      check("wrap_ir", 32'(ir), 32'(16'h51FF));
      step();
      check("wrap_pc", 32'(pc), 0);
      exec_done = 1'b1;
      step();
      clr();
      check("wrap_next_addr", 32'(mem_addr), 0);
      step();
      check("mid_if2_cmd", 32'(mem_cmd), 32'(C_READ));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_pc", 32'(pc), 0);
      check("mid_rst_ir", 32'(ir), 0);
      check("mid_rst_ir_valid", 32'(ir_valid), 0);
      check("mid_rst_cmd", 32'(mem_cmd), 32'(C_NONE));
      step();
      check("mid_refetch_cmd", 32'(mem_cmd), 32'(C_READ));
      check("mid_refetch_addr", 32'(mem_addr), 0);
      step();
      step();
      check("mid_refetch_ir", 32'(ir), 32'(16'hD105));

      // Opcode 3'b111
      ram[0] = 16'hE000;
`ifdef HALT_DETECT_EN
      n0 = n_start;
      do_reset();
      for (int i = 0; i < 24; i++) begin
         check("halt_pc", 32'(pc), 0);
         step();
      end
      check("halt_flag", 32'(halted), 1);
      check("halt_no_start", 32'(n_start - n0), 0);
      do_reset();
      check("halt_cleared", 32'(halted), 0);
`else
      do_reset();
      step();
      step();
      step();
      check("op7_start", 32'(exec_start), 1);
      check("op7_ir", 32'(ir), 32'(16'hE000));
      check("op7_halted", 32'(halted), 0);
      step();
      check("op7_pc", 32'(pc), 1);
`endif

      // Randomized program against an instruction-level model
      for (int k = 0; k < 512; k++) begin
         ram[k] = 16'($urandom);
`ifdef HALT_DETECT_EN
         if (ram[k][15:13] == 3'b111) ram[k][15] = 1'b0;
`endif
      end
      do_reset();
      exp_fetch = '0;
      abort = 1'b0;
      for (int n = 0; n < 40 && !abort; n++) begin
         waited = 0;
         while (exec_start !== 1'b1 && waited < 8) begin
            if (mem_cmd == C_READ) check("rnd_fetch_addr", 32'(mem_addr), 32'(exp_fetch));
            step();
            waited++;
         end
         if (exec_start !== 1'b1) begin
            check("rnd_start_timeout", 32'(exec_start), 1);
            abort = 1'b1;
         end else begin
            check("rnd_start_gap", 32'(waited), (n == 0) ? 3 : 2);
            check("rnd_ir", 32'(ir), 32'(ram[exp_fetch]));
            pc_m = exp_fetch + 9'd1;
            step();
            check("rnd_pc_inc", 32'(pc), 32'(pc_m));
            len = int'($urandom_range(1, 5));
            for (int c = 0; c < len; c++) begin
               dmem_req   = 1'($urandom_range(0, 1));
               dmem_write = 1'($urandom_range(0, 1));
               dmem_addr  = 9'($urandom);
               pc_load    = ($urandom_range(0, 3) == 0);
               pc_in      = 9'($urandom);
               exec_done  = (c == len - 1);
               #1;
               e_addr = dmem_req ? dmem_addr : pc_m;
               e_cmd  = dmem_req ? (dmem_write ? C_WRITE : C_READ) : C_NONE;
               check("rnd_mem_addr", 32'(mem_addr), 32'(e_addr));
               check("rnd_mem_cmd", 32'(mem_cmd), 32'(e_cmd));
               check("rnd_pc", 32'(pc), 32'(pc_m));
               if (pc_load) pc_m = pc_in;
               step();
            end
            clr();
            exp_fetch = pc_m;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
